// File: rtl/vram_scanout_if.sv
// Wishbone B-port bundle between the scan-out master and the 16K video RAM.
interface vram_scanout_if;
  logic [12:0] ADR_O;
  logic        CYC_O;
  logic        STB_O;
  logic        WE_O;
  logic [1:0]  SEL_O;
  logic [15:0] DAT_I;
  logic        ACK_I;

  modport master (
    output ADR_O, CYC_O, STB_O, WE_O, SEL_O,
    input  DAT_I, ACK_I
  );

  modport slave (
    input  ADR_O, CYC_O, STB_O, WE_O, SEL_O,
    output DAT_I, ACK_I
  );
endinterface

// File: rtl/vram_scanout.sv
// Video scan-out: Wishbone prefetch of framebuffer words into a FIFO, MSB-first pixel serialiser.
// Optional sticky underrun flag enabled by defining VRAM_SCANOUT_UNDERRUN_EN.
module vram_scanout #(
  parameter logic [12:0] FB_BASE         = 13'h0000,
  parameter int          WORDS_PER_FRAME = 8000,
  parameter int          FIFO_DEPTH      = 8
) (
  input  logic               CLK_I,
  input  logic               RST_I,
  vram_scanout_if.master     wb,
  input  logic               VSYNC_I,
  input  logic               DEN_I,
  output logic               PIXEL_O,
  output logic               UNDERRUN_O
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REM_W = $clog2(WORDS_PER_FRAME + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [12:0]      adr_q, adr_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [15:0]      shift_q, shift_d;
  logic             pixel_q, pixel_d;
  logic [15:0]      mem_q [FIFO_DEPTH];

  logic push;
  logic pop;
  logic fifo_full;
  logic fifo_empty;

  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Fetch FSM. An entry is only requested from IDLE, where no word is in flight,
  // so the occupancy count alone decides whether a slot is free.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    adr_d   = adr_q;
    rem_d   = rem_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: if (rem_q != '0 && !fifo_full) state_d = ST_BUS;
      ST_BUS: begin
        if (wb.ACK_I) begin
          push    = 1'b1;
          adr_d   = adr_q + 13'd1;
          rem_d   = rem_q - REM_W'(1);
          state_d = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (VSYNC_I) begin
      state_d = ST_GAP;
      adr_d   = FB_BASE;
      rem_d   = REM_W'(WORDS_PER_FRAME);
      push    = 1'b0;
    end
  end

  // Serialiser: reload from the FIFO head every 16th enabled pixel.
  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    pop      = 1'b0;
    if (VSYNC_I) begin
      shift_d  = '0;
      bitcnt_d = '0;
    end else if (DEN_I) begin
      if (bitcnt_q == 4'd0) begin
        if (!fifo_empty) begin
          shift_d = mem_q[rd_ptr_q];
          pop     = 1'b1;
        end else begin
          shift_d = 16'h0000;
        end
      end else begin
        shift_d = {shift_q[14:0], 1'b0};
      end
      bitcnt_d = bitcnt_q + 4'd1;
    end else begin
      bitcnt_d = '0;
    end
    pixel_d = DEN_I & shift_d[15];
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (VSYNC_I) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK_I) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (RST_I) begin
      state_q  <= ST_IDLE;
      adr_q    <= FB_BASE;
      rem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      pixel_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      rem_q    <= rem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      pixel_q  <= pixel_d;
    end
  end

  // NOTE: FIFO storage is not reset; the pointers and count define which entries are valid.
  always_ff @(posedge CLK_I) begin
    if (push) mem_q[wr_ptr_q] <= wb.DAT_I;
  end

`ifdef VRAM_SCANOUT_UNDERRUN_EN
  logic underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (VSYNC_I) underrun_d = 1'b0;
    else if (DEN_I && bitcnt_q == 4'd0 && fifo_empty) underrun_d = 1'b1;
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) underrun_q <= 1'b0;
    else       underrun_q <= underrun_d;
  end

  assign UNDERRUN_O = underrun_q;
`else
  assign UNDERRUN_O = 1'b0;
`endif

  assign wb.CYC_O = (state_q == ST_BUS);
  assign wb.STB_O = (state_q == ST_BUS);
  assign wb.ADR_O = adr_q;
  assign wb.WE_O  = 1'b0;
  assign wb.SEL_O = 2'b11;
  assign PIXEL_O  = pixel_q;

endmodule

// File: doc/vram_scanout.md
Name: vram_scanout

Overview:
- Video scan-out stage, directly downstream of the 16K video RAM's B port.
- Acts as a Wishbone master on that port and prefetches 16-bit framebuffer words into a small FIFO.
- Serialises the words MSB-first into a 1-bit pixel stream for the 640x200 monochrome display.
- Sync timing comes from an external timing generator via VSYNC_I and DEN_I.

Parameters:
- FB_BASE, 13'h0000: word address of the first framebuffer word.
- WORDS_PER_FRAME, 8000: words fetched per frame (640x200/16).
- FIFO_DEPTH, 8: prefetch FIFO entries; must be a power of two, at least 2.

Ports:
- CLK_I  in  1  system clock.
- RST_I  in  1  reset. One clock; reset is synchronous and active-high.
- ADR_O  out  13  word address [13:1] to the VRAM B port.
- CYC_O  out  1  Wishbone cycle.
- STB_O  out  1  Wishbone strobe.
- WE_O  out  1  always 0.
- SEL_O  out  2  always 2'b11.
- DAT_I  in  16  read data from VRAM.
- ACK_I  in  1  VRAM acknowledge.
- VSYNC_I  in  1  one-cycle frame-start pulse.
- DEN_I  in  1  display enable; high for each active pixel clock.
- PIXEL_O  out  1  serial pixel, 1 = lit.
- UNDERRUN_O  out  1  sticky underrun flag (optional feature only).

Behaviour:
- Reset values:
  - CYC_O=STB_O=0, ADR_O=FB_BASE, PIXEL_O=0, UNDERRUN_O=0.
  - FIFO empty, bit counter 0, shifter 0.
  - Words-remaining = 0: no fetch until the first VSYNC_I.
- Slave contract: the VRAM ACKs one cycle after sampling STB and does not pipeline. The master therefore holds STB until ACK, then deasserts for at least one cycle.
- Fetch FSM states:
  - IDLE: CYC/STB low. Go to BUS when remaining>0 and FIFO has a free slot, counting any word in flight.
  - BUS: CYC=STB=1, ADR_O = current address. Hold until ACK_I.
    - On ACK: push DAT_I, address+1, remaining-1, go to GAP.
  - GAP: CYC/STB low for exactly one cycle, then go to IDLE. ACK_I is ignored here.
- Address arithmetic:
  - 13-bit, wraps 13'h1FFF -> 13'h0000.
  - Remaining reaching 0 stops fetching until the next VSYNC_I.
- VSYNC_I (highest priority, any state):
  - Next cycle: CYC/STB low, state = GAP (abort; any ACK in flight is discarded).
  - FIFO flushed, ADR_O = FB_BASE, remaining = WORDS_PER_FRAME.
  - Bit counter and shifter cleared.
- ACK_I seen in IDLE or GAP: ignored, no push.
- Serializer, on a cycle with DEN_I=1:
  - If bitcnt==0: shifter <= FIFO head and pop. If the FIFO is empty, load 16'h0000 and flag underrun.
  - Otherwise: shifter <= shifter<<1.
  - bitcnt increments mod 16.
- Serializer, on a cycle with DEN_I=0: bitcnt forced to 0, shifter holds.
- Pixel output:
  - PIXEL_O is registered: it equals shifter[15] in the cycle after a DEN_I=1 cycle, else 0.
  - The first pixel of a line appears 1 cycle after DEN_I rises, so pixels lag DEN_I by exactly one clock.
- FIFO:
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Push is never issued when full (guaranteed by the IDLE check).
  - Pop when empty never corrupts the count.
- Reset mid-bus-cycle: CYC/STB drop the next cycle and state returns to reset values.

Optional Feature:
- Macro: VRAM_SCANOUT_UNDERRUN_EN.
- Defined:
  - UNDERRUN_O is set the cycle after a pop on an empty FIFO.
  - Sticky; cleared only by RST_I or VSYNC_I.
- Undefined:
  - UNDERRUN_O is tied 0.
  - Underrun still loads 16'h0000 (blank pixels).

Test Plan:
- Fill: reset, pulse VSYNC_I, DEN_I=0, with a VRAM model acking one cycle after STB.
  - Required: exactly 8 reads at ADR 0..7.
  - Each STB high for 2 cycles, low for at least 1 between reads.
  - Fetching then stops with FIFO full.
- Serialize: VRAM word0=16'hAAAA, word1=16'hFFFF; after fill, DEN_I high for 32 cycles.
  - Required: PIXEL_O shows 1010... for 16 cycles, then 1 for 16 cycles, starting 1 cycle after DEN_I rises.
  - Refetch of ADR 8 begins after the first pop.
- Frame end: WORDS_PER_FRAME=10, continuous DEN_I.
  - Required: exactly 10 reads, ADR 0..9, then CYC_O stays 0.
  - Next VSYNC_I restarts at FB_BASE.
- Abort: VSYNC_I in the same cycle STB_O is first high.
  - Required: STB_O low next cycle, the pending ACK does not push, the next read is at FB_BASE.
- Underrun (feature on): VRAM model delays ACK 40 cycles, DEN_I continuous.
  - Required: PIXEL_O=0 for blank words and UNDERRUN_O=1.
  - UNDERRUN_O stays 1 until VSYNC_I clears it.
- Reset: RST_I during BUS.
  - Required: next cycle CYC_O=STB_O=0, ADR_O=FB_BASE, PIXEL_O=0, no fetch until VSYNC_I.
